// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Owns the architectural fetch PC, arbitrates prioritised redirect channels,
// drives a valid/ready fetch request whose address stays put while stalled,
// and buffers a redirect that arrives during a stall (flagging the
// outstanding request as wrong-path until it is accepted).
module pc_gen #(
  parameter int unsigned     XLEN         = 64,
  parameter int unsigned     NUM_REDIRECT = 2,
  parameter int unsigned     INST_BYTES   = 4,
  parameter logic [XLEN-1:0] RESET_PC     = 'h8000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REDIRECT-1:0]      redirect_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0] redirect_target,
  output logic [NUM_REDIRECT-1:0]      redirect_grant,
  output logic [XLEN-1:0]              pc,
  output logic                         pc_valid,
  input  logic                         pc_ready,
  output logic                         pc_wrong_path
);

  // Clears the low log2(INST_BYTES) bits of a redirect target.
  localparam logic [XLEN-1:0] AlignMask = ~(XLEN'(INST_BYTES - 1));
  localparam logic [XLEN-1:0] IncBytes  = XLEN'(INST_BYTES);

  // BOOT: request not yet valid. RUN: normal fetch. HOLD: redirect buffered
  // behind a stalled request.
  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  logic            any;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] aligned_target;
  logic            fire;
  logic            stall;
  logic            pend;

  // Fixed-priority arbiter: walk from the top so the lowest active index wins.
  always_comb begin
    any            = 1'b0;
    sel_target     = '0;
    redirect_grant = '0;
    for (int i = int'(NUM_REDIRECT) - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        any               = 1'b1;
        sel_target        = redirect_target[i*XLEN +: XLEN];
        redirect_grant    = '0;
        redirect_grant[i] = 1'b1;
      end
    end
  end

  assign aligned_target = sel_target & AlignMask;

  // Handshake qualifiers seen by the next-state logic.
  always_comb begin
    pend  = (state_q == StHold);
    fire  = pc_valid & pc_ready;
    stall = pc_valid & ~pc_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: HOLD is entered on a stalled redirect and left when the
  // stalled request fires or a fresh redirect lands without a stall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (any && stall) state_d = StHold;
      end
      StHold: begin
        if (any && stall)   state_d = StHold;
        else if (any)       state_d = StRun;
        else if (fire)      state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    pc_valid      = 1'b0;
    pc_wrong_path = 1'b0;
    unique case (state_q)
      StBoot: begin
        pc_valid      = 1'b0;
        pc_wrong_path = 1'b0;
      end
      StRun: begin
        pc_valid      = 1'b1;
        pc_wrong_path = 1'b0;
      end
      StHold: begin
        pc_valid      = 1'b1;
        pc_wrong_path = 1'b1;
      end
      default: begin
        pc_valid      = 1'b0;
        pc_wrong_path = 1'b0;
      end
    endcase
  end

  // PC / buffered-target next state. A stalled request keeps its address;
  // a redirect seen during the stall only updates the buffer, newest wins.
  always_comb begin
    pc_d  = pc_q;
    tgt_d = tgt_q;
    if (any && stall) begin
      tgt_d = aligned_target;
    end else if (any) begin
      // Taken even when the current request fires: the redirecting source
      // owns squashing whatever was accepted this cycle.
      pc_d = aligned_target;
    end else if (pend && fire) begin
      pc_d = tgt_q;
    end else if (fire) begin
      pc_d = pc_q + IncBytes;
    end
  end

  // PC and buffered-target registers; reset drops any buffered redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      tgt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      tgt_q <= tgt_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end: owns the architectural fetch PC register and chooses each cycle between sequential increment, hold, and one of NUM_REDIRECT prioritised redirect channels (trap, branch, jump, ...). It drives a valid/ready fetch-request handshake and keeps an outstanding request address stable. A redirect that arrives while the request is stalled is buffered and marks the in-flight request as wrong-path.

## Interface
Parameters:
- XLEN, 64, PC and target width.
- NUM_REDIRECT, 2, number of redirect channels (>=1); channel 0 has highest priority.
- INST_BYTES, 4, sequential increment; power of two.
- RESET_PC, 64'h8000_0000, PC value loaded by reset.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  NUM_REDIRECT  per-channel redirect request.
- redirect_target  in  NUM_REDIRECT*XLEN  flattened targets; channel i at [i*XLEN +: XLEN].
- redirect_grant  out  NUM_REDIRECT  one-hot, combinational; the winning channel this cycle, or all zero.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  fetch request valid.
- pc_ready  in  1  fetch side accepts pc this cycle.
- pc_wrong_path  out  1  the outstanding request is stale; fetch must discard its response.

## Operation
- Registered state: pc_q, valid_q, pend_q (buffered redirect present), tgt_q (buffered target).
- Arbitration: sel = lowest index i with redirect_valid[i]; any = |redirect_valid. redirect_grant[sel] = any.
- Alignment: the selected target's low log2(INST_BYTES) bits are forced to 0 before use.
- fire = pc_valid & pc_ready. stall = pc_valid & ~pc_ready.
- Next-state priority, evaluated each non-reset cycle:
  1. any & stall: pc_q held; pend_q <= 1; tgt_q <= aligned target(sel). A newer redirect overwrites an older buffered one.
  2. any & ~stall: pc_q <= aligned target(sel); pend_q <= 0. This applies even if fire; the request accepted this cycle is the redirecting source's responsibility.
  3. ~any & pend_q & fire: pc_q <= tgt_q; pend_q <= 0.
  4. ~any & ~pend_q & fire: pc_q <= pc_q + INST_BYTES, modulo 2^XLEN.
  5. Otherwise: hold.
- valid_q <= 1 every non-reset cycle. pc_valid = valid_q; it never drops after boot. Back-pressure is expressed only through pc_ready.
- pc = pc_q. pc_wrong_path = pend_q.
- States, derived from the registers:
  - BOOT (valid_q=0): goes to RUN.
  - RUN (valid_q=1, pend_q=0): goes to HOLD on any & stall.
  - HOLD (pend_q=1): goes to RUN on fire (PC becomes tgt_q) or on a redirect with ~stall.

## Timing
- Reset (sync, at posedge with reset=1), required output values: pc=RESET_PC, pc_valid=0, pc_wrong_path=0. redirect_grant stays combinational.
- First cycle after reset deasserts: pc_valid=0 (BOOT). From the next cycle: pc_valid=1, pc=RESET_PC.
- Redirect latency: a redirect in cycle t with no stall appears on pc in cycle t+1.
- A stalled redirect appears on pc in the cycle after the stalled request fires.
- Sequential throughput: one PC per cycle while pc_ready=1.
- The pc value must not change while pc_valid=1 and pc_ready=0, including across redirects.
- Wrap-around: pc=2^XLEN-INST_BYTES, fire → pc=0.
- Reset asserted mid-HOLD: the buffered redirect is discarded and state returns to the reset values.
- Simultaneous events:
  - Multiple channels active: the lowest index wins.
  - Redirect in the same cycle as a buffered-redirect fire: the new redirect wins (rule 2).

## Test plan
- Boot: reset 2 cycles, then pc_ready=1 held → pc_valid 0 for one cycle, then pc = 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
- Priority: redirect_valid=2'b11, targets ch0=0x100 and ch1=0x200, no stall → redirect_grant=2'b01, pc=0x100 next cycle, then 0x104.
- Stalled redirect: pc=0x8000_0010, pc_ready=0, ch1 redirect to 0x3002 for one cycle → pc stays 0x8000_0010 and pc_wrong_path=1. Then raise pc_ready → pc=0x3000 the following cycle (aligned), pc_wrong_path=0.
- Overwrite in HOLD: while stalled, redirect to 0x400, then to 0x500 → after fire, pc=0x500.
- Wrap: force pc via redirect to 0xFFFF_FFFF_FFFF_FFFC, fire → pc=0.
- Reset mid-HOLD: enter HOLD with target 0x600, assert reset 1 cycle → pc=0x8000_0000, pc_wrong_path=0, and 0x600 never issued.
